// File: rtl/link_sched_pkg.sv
// Shared constants and source encodings for the serializer word scheduler.
package link_sched_pkg;

  localparam logic [15:0] SYNC_PATTERN = 16'h817E;

  typedef enum logic [1:0] {
    SRC_SYNC = 2'd0,
    SRC_TRIG = 2'd1,
    SRC_CMD  = 2'd2
  } src_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first unmasked request at or after ptr.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]  eff;
  logic [IW-1:0] idx;
  logic          found;

  assign eff = req & ~mask;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!found && eff[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/link_word_scheduler.sv
// Chooses the next serializer word: lock preamble, periodic sync, trigger and
// round-robin command words. Decisions happen only on word_sent edges.
module link_word_scheduler
  import link_sched_pkg::*;
#(
  parameter int unsigned       NUM_REQ       = 4,
  parameter int unsigned       WORD_W        = 16,
  parameter int unsigned       LOCK_WORDS    = 24,
  parameter int unsigned       SYNC_INTERVAL = 32,
  parameter logic [WORD_W-1:0] SYNC_PATTERN  = WORD_W'(link_sched_pkg::SYNC_PATTERN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      word_sent,
  input  logic                      trig_req,
  input  logic [WORD_W-1:0]         trig_word,
  input  logic [NUM_REQ-1:0]        cmd_req,
  input  logic [NUM_REQ*WORD_W-1:0] cmd_word,
  output logic [WORD_W-1:0]         ser_word,
  output logic [1:0]                src,
  output logic                      trig_ack,
  output logic [NUM_REQ-1:0]        cmd_ack,
  output logic                      locking
);

  localparam int unsigned PTR_W    = $clog2(NUM_REQ);
  localparam int unsigned SYNC_MAX = 2 * SYNC_INTERVAL;
  localparam int unsigned SC_W     = $clog2(SYNC_MAX + 1);
  localparam int unsigned LC_W     = $clog2(LOCK_WORDS + 1);

  logic [LC_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [SC_W-1:0]    sync_cnt_q, sync_cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WORD_W-1:0]  ser_word_q, ser_word_d;
  src_e               src_q, src_d;
  logic [NUM_REQ-1:0] sel_q, sel_d;  // one-hot cmd owner of ser_word_q
  logic               trig_ack_q, trig_ack_d;
  logic [NUM_REQ-1:0] cmd_ack_q, cmd_ack_d;

  logic               trig_mask;
  logic [NUM_REQ-1:0] cmd_mask;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;

  assign trig_mask = (src_q == SRC_TRIG);
  assign cmd_mask  = (src_q == SRC_CMD) ? sel_q : '0;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req   (cmd_req),
    .mask  (cmd_mask),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .valid (grant_valid)
  );

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    sync_cnt_d = sync_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    ser_word_d = ser_word_q;
    src_d      = src_q;
    sel_d      = sel_q;
    trig_ack_d = 1'b0;
    cmd_ack_d  = '0;
    if (word_sent) begin
      // The word in ser_word_q is committed now; ack its owner next cycle.
      trig_ack_d = trig_mask;
      cmd_ack_d  = cmd_mask;
      ser_word_d = SYNC_PATTERN;
      src_d      = SRC_SYNC;
      sel_d      = '0;
      if (lock_cnt_q < LC_W'(LOCK_WORDS)) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end else if (sync_cnt_q >= SC_W'(SYNC_MAX)) begin
        src_d = SRC_SYNC;
      end else if (trig_req && !trig_mask) begin
        ser_word_d = trig_word;
        src_d      = SRC_TRIG;
      end else if (sync_cnt_q >= SC_W'(SYNC_INTERVAL)) begin
        src_d = SRC_SYNC;
      end else if (grant_valid) begin
        src_d      = SRC_CMD;
        sel_d      = grant;
        ser_word_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant[i]) begin
            ser_word_d = cmd_word[i*WORD_W +: WORD_W];
            rr_ptr_d   = PTR_W'((i + 1) % NUM_REQ);
          end
        end
      end
      if (src_d == SRC_SYNC) begin
        sync_cnt_d = '0;
      end else if (sync_cnt_q != SC_W'(SYNC_MAX)) begin
        sync_cnt_d = sync_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= '0;
      sync_cnt_q <= '0;
      rr_ptr_q   <= '0;
      ser_word_q <= SYNC_PATTERN;
      src_q      <= SRC_SYNC;
      sel_q      <= '0;
      trig_ack_q <= 1'b0;
      cmd_ack_q  <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      ser_word_q <= ser_word_d;
      src_q      <= src_d;
      sel_q      <= sel_d;
      trig_ack_q <= trig_ack_d;
      cmd_ack_q  <= cmd_ack_d;
    end
  end

  assign ser_word = ser_word_q;
  assign src      = src_q;
  assign trig_ack = trig_ack_q;
  assign cmd_ack  = cmd_ack_q;
  assign locking  = (lock_cnt_q < LC_W'(LOCK_WORDS));

endmodule

// File: tb/tb_link_word_scheduler.sv
// Self-checking bench: directed phases plus randomized requesters against a behavioural model.
module tb_link_word_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           word_sent = 1'b0;
  logic           trig_req = 1'b0;
  logic [W-1:0]   trig_word = '0;
  logic [N-1:0]   cmd_req = '0;
  logic [N*W-1:0] cmd_word = '0;
  logic [W-1:0]   ser_word;
  logic [1:0]     src;
  logic           trig_ack;
  logic [N-1:0]   cmd_ack;
  logic           locking;

  always #5 clk = ~clk;

  link_word_scheduler #(
    .NUM_REQ       (N),
    .WORD_W        (W),
    .LOCK_WORDS    (24),
    .SYNC_INTERVAL (32),
    .SYNC_PATTERN  (16'h817E)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .word_sent (word_sent),
    .trig_req  (trig_req),
    .trig_word (trig_word),
    .cmd_req   (cmd_req),
    .cmd_word  (cmd_word),
    .ser_word  (ser_word),
    .src       (src),
    .trig_ack  (trig_ack),
    .cmd_ack   (cmd_ack),
    .locking   (locking)
  );

  int nchk = 0;
  int nfail = 0;

  // Behavioural model: owner -1 sync, -2 trigger, >=0 command source index.
  int           m_lock, m_sync, m_ptr, m_owner;
  logic [W-1:0] m_word;
  logic [1:0]   m_src;
  logic         m_trig_ack;
  logic [N-1:0] m_cmd_ack;

  bit           hold_trig;
  logic [N-1:0] hold_cmd;
  int           ack_total;
  int           ack_seq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ser_word"}, 32'(ser_word), 32'(m_word));
    chk({tag, " src"}, 32'(src), 32'(m_src));
    chk({tag, " trig_ack"}, 32'(trig_ack), 32'(m_trig_ack));
    chk({tag, " cmd_ack"}, 32'(cmd_ack), 32'(m_cmd_ack));
    chk({tag, " locking"}, 32'(locking), (m_lock < 24) ? 32'd1 : 32'd0);
  endtask

  function automatic void model_reset();
    m_lock = 0; m_sync = 0; m_ptr = 0; m_owner = -1;
    m_word = 16'h817E; m_src = 2'd0; m_trig_ack = 1'b0; m_cmd_ack = '0;
  endfunction

  function automatic void model_edge();
    int commit;
    bit found;
    m_trig_ack = 1'b0;
    m_cmd_ack  = '0;
    if (!word_sent) return;
    commit = m_owner;
    if (commit == -2) m_trig_ack = 1'b1;
    if (commit >= 0) m_cmd_ack[commit] = 1'b1;
    m_owner = -1;
    if (m_lock < 24) begin
      m_lock++;
    end else if (m_sync >= 64) begin
      m_owner = -1;
    end else if (trig_req && commit != -2) begin
      m_owner = -2;
      m_word  = trig_word;
    end else if (m_sync >= 32) begin
      m_owner = -1;
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!found && cmd_req[i] && i != commit) begin
          found   = 1;
          m_owner = i;
          m_word  = cmd_word[i*W +: W];
          m_ptr   = (i + 1) % N;
        end
      end
    end
    if (m_owner == -1) begin
      m_word = 16'h817E;
      m_src  = 2'd0;
      m_sync = 0;
    end else begin
      m_src  = (m_owner == -2) ? 2'd1 : 2'd2;
      m_sync = (m_sync < 64) ? m_sync + 1 : 64;
    end
  endfunction

  // One clock: update model at the edge, check just after it, then let requesters react.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all(tag);
    word_sent = 1'b0;
    if (trig_ack) begin
      ack_total++;
      trig_req  = 1'b0;
      trig_word = 16'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      if (cmd_ack[i]) begin
        ack_total++;
        ack_seq.push_back(i);
        cmd_req[i] = 1'b0;
        cmd_word[i*W +: W] = 16'($urandom);
      end
    end
  endtask

  task automatic send(input int gap, input string tag);
    if (!trig_req && hold_trig) trig_req = 1'b1;
    cmd_req   = hold_cmd;
    word_sent = 1'b1;
    tick(tag);
    for (int g = 1; g < gap; g++) tick(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, " immediate"});
    word_sent = 1'b1;
    tick({tag, " held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    hold_trig = 0;
    hold_cmd  = '0;
    ack_total = 0;
    for (int i = 0; i < N; i++) cmd_word[i*W +: W] = 16'hC000 | 16'(i << 8);
    trig_word = 16'hA5A5;

    // Reset values, and word_sent ignored while reset is held.
    tick("reset");
    word_sent = 1'b1;
    tick("reset_ws");
    @(negedge clk);
    rst = 1'b0;

    // Preamble then idle syncs.
    for (int n = 1; n <= 30; n++) begin
      send(16, "lock");
      if (n == 23) chk("locking_at_23", 32'(locking), 32'd1);
      if (n == 24) chk("locking_at_24", 32'(locking), 32'd0);
    end

    // All four command sources held: round-robin ack order.
    ack_seq.delete();
    hold_cmd = 4'b1111;
    for (int n = 0; n < 12; n++) send(3, "rr4");
    chk("rr_ack_count_ge8", 32'(ack_seq.size() >= 8), 32'd1);
    for (int k = 0; k < ack_seq.size() && k < 8; k++) chk("rr_order", 32'(ack_seq[k]), 32'(k % 4));
    hold_cmd = '0;
    for (int n = 0; n < 4; n++) send(3, "drain");

    // Single command source held.
    hold_cmd = 4'b0001;
    for (int n = 0; n < 40; n++) send(2, "cmd0");
    hold_cmd = '0;
    for (int n = 0; n < 3; n++) send(2, "drain");

    // Trigger and command 2 arrive together.
    hold_trig = 1; hold_cmd = 4'b0100;
    send(3, "trig_cmd2");
    hold_trig = 0; hold_cmd = '0;
    for (int n = 0; n < 4; n++) send(3, "trig_cmd2");

    // Trigger held alone, then trigger with a command source.
    hold_trig = 1;
    for (int n = 0; n < 40; n++) send(2, "trig_hold");
    hold_cmd = 4'b0010;
    for (int n = 0; n < 80; n++) send(2, "trig_cmd1");
    hold_trig = 0; hold_cmd = '0;
    for (int n = 0; n < 3; n++) send(2, "drain");

    // Randomized requesters.
    for (int n = 0; n < 300; n++) begin
      hold_trig = ($urandom_range(0, 3) == 0);
      hold_cmd  = 4'($urandom);
      if ($urandom_range(0, 7) == 0) trig_req = 1'b0;
      send($urandom_range(2, 4), "random");
    end

    // Reset mid-preamble, replay full preamble with no acks.
    hold_trig = 0; hold_cmd = '0;
    async_reset("rst_preamble");
    for (int n = 0; n < 10; n++) send(2, "pre_a");
    async_reset("rst_mid_preamble");
    hold_trig = 1; hold_cmd = 4'b1111; ack_total = 0;
    for (int n = 0; n < 24; n++) send(2, "replay");
    chk("no_ack_during_preamble", 32'(ack_total), 32'd0);
    for (int n = 0; n < 3; n++) send(2, "after_replay");
    chk("ack_after_preamble", 32'(ack_total > 0), 32'd1);

    // Reset while a command word is pending in ser_word.
    hold_trig = 0;
    begin
      bit got_cmd;
      got_cmd = 0;
      for (int n = 0; n < 10 && !got_cmd; n++) begin
        send(2, "seek_cmd");
        got_cmd = (m_src == 2'd2);
      end
      chk("cmd_word_pending", 32'(got_cmd), 32'd1);
    end
    async_reset("rst_mid_cmd");
    ack_total = 0;
    for (int n = 0; n < 24; n++) send(2, "replay2");
    chk("no_ack_replay2", 32'(ack_total), 32'd0);
    hold_cmd = '0;
    for (int n = 0; n < 4; n++) send(2, "final");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
